// File: rtl/fiber_source_if.sv
// Loader-to-fiber_source write channel: one coordinate per accepted beat.
// Transfer on a rising clock edge when wr_valid && wr_ready; wr_coord/wr_last are meaningful only while wr_valid is high.
interface fiber_source_if;
  logic [63:0] wr_coord;
  logic        wr_last;
  logic        wr_valid;
  logic        wr_ready;

  modport master (output wr_coord, output wr_last, output wr_valid, input wr_ready);
  modport slave  (input wr_coord, input wr_last, input wr_valid, output wr_ready);
endinterface

// File: rtl/fiber_source.sv
// Leaf feeder for the merger tree: buffers one sorted fiber in a show-ahead FIFO and
// presents the head coordinate, or the END sentinel once the fiber has been consumed.
module fiber_source #(
  parameter int          DEPTH = 8,
  parameter logic [63:0] END   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  fiber_source_if.slave          wr,
  output logic [63:0]            coord,
  output logic                   coord_valid,
  input  logic                   fetch_next,
  input  logic                   restart,
  output logic                   done,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   CAP     = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop, err_set;
  logic [63:0]   head_coord;
  logic          head_last;

  assign head_coord  = mem[rd_ptr][63:0];
  assign head_last   = mem[rd_ptr][64];
  assign wr.wr_ready = (state == S_FILL) && (count < CAP);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = fetch_next && (count != '0) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign occupancy   = count;
  assign dbg_state   = state;

  // A held entry always wins; END is shown only as a valid sentinel in DONE.
  always_comb begin
    coord       = END;
    coord_valid = 1'b0;
    if (count != '0) begin
      coord       = head_coord;
      coord_valid = 1'b1;
    end else if (state == S_DONE) begin
      coord_valid = 1'b1;
    end
  end

  assign err_set = (fetch_next && !coord_valid) || (push && (wr.wr_coord == END));

  always_comb begin
    state_nx = state;
    if (restart) begin
      state_nx = S_FILL;
    end else begin
      case (state)
        S_FILL:  if (push && wr.wr_last) state_nx = S_DRAIN;
        S_DRAIN: if (pop && head_last)   state_nx = S_DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_FILL;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (restart) begin
      state  <= S_FILL;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (err_set) err <= 1'b1;
    end
  end

  // Storage is not reset; count and pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push && !restart) mem[wr_ptr] <= {wr.wr_last, wr.wr_coord};
  end

endmodule

// File: tb/tb_fiber_source.sv
// Bench for fiber_source: queue-based fiber model, per-cycle status checks and a
// decoupled monitor that matches every consumed coordinate against the expected queue.
module tb_fiber_source;
  localparam int          DEPTH = 8;
  localparam logic [63:0] END_C = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] coord;
  logic        coord_valid;
  logic        fetch_next;
  logic        restart;
  logic        done;
  logic [3:0]  occupancy;
  logic        err;
  logic [1:0]  dbg_state;

  fiber_source_if wif();

  fiber_source #(.DEPTH(DEPTH), .END(END_C)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr          (wif),
    .coord       (coord),
    .coord_valid (coord_valid),
    .fetch_next  (fetch_next),
    .restart     (restart),
    .done        (done),
    .occupancy   (occupancy),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [64:0] model_q[$];
  bit          m_got_last, m_done, m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    m_got_last = 1'b0;
    m_done     = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic check_status();
    bit          rdy, cv;
    logic [63:0] hd;
    rdy = !m_got_last && (model_q.size() < DEPTH);
    cv  = (model_q.size() > 0) || m_done;
    hd  = (model_q.size() > 0) ? model_q[0][63:0] : END_C;
    chk("occupancy",   64'(occupancy),   64'(model_q.size()));
    chk("wr_ready",    64'(wif.wr_ready), 64'(rdy));
    chk("coord_valid", 64'(coord_valid), 64'(cv));
    chk("coord",       coord,            hd);
    chk("done",        64'(done),        64'(m_done));
    chk("err",         64'(err),         64'(m_err));
  endtask

  // One clock of stimulus; called and returns at a falling edge.
  task automatic step(input bit wv, input logic [63:0] wc, input bit wl, input bit fn, input bit rs);
    bit          rdy, cv, acc, pp;
    logic [64:0] e;
    wif.wr_valid = wv;
    wif.wr_coord = wc;
    wif.wr_last  = wl;
    fetch_next   = fn;
    restart      = rs;
    rdy = !m_got_last && (model_q.size() < DEPTH);
    cv  = (model_q.size() > 0) || m_done;
    acc = wv && rdy;
    pp  = fn && (model_q.size() > 0) && !m_done;
    if (pp && !rs) exp_q.push_back(model_q[0][63:0]);
    @(posedge clock);
    if (rs) begin
      model_clear();
    end else begin
      if ((fn && !cv) || (acc && wc == END_C)) m_err = 1'b1;
      if (pp) begin
        e = model_q.pop_front();
        if (e[64]) m_done = 1'b1;
      end
      if (acc) begin
        model_q.push_back({wl, wc});
        if (wl) m_got_last = 1'b1;
      end
    end
    @(negedge clock);
    check_status();
  endtask

  // Monitor: whenever the DUT is about to hand a coordinate over, it must match the model.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (reset && !restart && fetch_next && coord_valid && !done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected at %0t: got coord %0h expected no pop", $time, coord);
        end else begin
          chk("pop_coord", coord, exp_q.pop_front());
        end
      end
    end
  end

  logic [63:0] cur;
  bit          r_wv, r_wl, r_fn, r_rs;
  logic [63:0] r_wc;

  initial begin
    reset        = 1'b0;
    wif.wr_valid = 1'b0;
    wif.wr_coord = '0;
    wif.wr_last  = 1'b0;
    fetch_next   = 1'b0;
    restart      = 1'b0;
    model_clear();
    wif.wr_valid = 1'b1;
    wif.wr_coord = 64'd99;
    repeat (2) @(negedge clock);
    check_status();
    wif.wr_valid = 1'b0;
    reset = 1'b1;

    // fill and drain, then a legal fetch in DONE
    step(1, 64'd3, 0, 0, 0);
    step(1, 64'd7, 0, 0, 0);
    step(1, 64'd12, 1, 0, 0);
    repeat (4) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 1);

    // full, then pop with a concurrent write that must be refused once
    for (int i = 0; i < DEPTH; i++) step(1, 64'(100 + i * 5), 0, 0, 0);
    step(1, 64'd500, 0, 1, 0);
    step(1, 64'd500, 0, 0, 0);
    step(0, '0, 0, 0, 1);

    // steady push+pop at occupancy 2, wrapping the pointers
    step(1, 64'd1000, 0, 0, 0);
    step(1, 64'd1001, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 64'(1002 + i), 0, 1, 0);
    step(0, '0, 0, 0, 1);

    // errors: fetch on empty, and writing the sentinel
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 1);
    step(1, END_C, 0, 0, 0);

    // restart with 4 entries and err set, then a one-entry fiber
    step(1, 64'd20, 0, 0, 0);
    step(1, 64'd21, 0, 0, 0);
    step(1, 64'd22, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(1, 64'd5, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 1);

    // randomized fibers with occasional restarts and sentinel writes
    cur = 64'd0;
    for (int i = 0; i < 400; i++) begin
      r_wv = ($urandom_range(0, 3) != 0);
      r_wl = ($urandom_range(0, 14) == 0);
      r_fn = ($urandom_range(0, 2) != 0);
      r_rs = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) begin
        r_wc = END_C;
      end else begin
        cur  = cur + 64'($urandom_range(1, 50));
        r_wc = cur;
      end
      step(r_wv, r_wc, r_wl, r_fn, r_rs);
    end
    step(0, '0, 0, 0, 1);

    // asynchronous reset in the middle of DRAIN
    step(1, 64'd40, 0, 0, 0);
    step(1, 64'd41, 0, 0, 0);
    step(1, 64'd42, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    fetch_next = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_coord",       coord,               END_C);
    chk("rst_coord_valid", 64'(coord_valid),    64'd0);
    chk("rst_done",        64'(done),           64'd0);
    chk("rst_err",         64'(err),            64'd0);
    chk("rst_occupancy",   64'(occupancy),      64'd0);
    chk("rst_wr_ready",    64'(wif.wr_ready),   64'd1);
    model_clear();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    check_status();
    step(1, 64'd77, 1, 0, 0);
    step(0, '0, 0, 1, 0);

    @(negedge clock);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fiber_source.md
# fiber_source

Stream feeder that sits at each leaf input of the merger tree and answers its `fetch_next` pull: it buffers one sparse fiber of sorted 64-bit coordinates from the fiber loader and presents the current head coordinate to a merger `coord_N` input. It pops one entry per `fetch_next` pulse. When the fiber is exhausted it presents the end-of-fiber sentinel, so the merger never selects that input again. It also exposes valid, done and occupancy status to the tree controller, which gates `selected` until every leaf is valid.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `END`, 64'hFFFF_FFFF_FFFF_FFFF, end-of-fiber sentinel coordinate.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_coord`  in  64  coordinate from the loader.
- `wr_last`  in  1  marks `wr_coord` as the final coordinate of the fiber.
- `wr_valid`  in  1  loader has a coordinate.
- `wr_ready`  out  1  block accepts a write this cycle.
- `coord`  out  64  head coordinate to the merger `coord_N`.
- `coord_valid`  out  1  `coord` is meaningful: a real head or `END` after done.
- `fetch_next`  in  1  merger pop request, one pulse per consumed coordinate.
- `restart`  in  1  synchronous flush that prepares for the next fiber.
- `done`  out  1  last coordinate has been popped.
- `occupancy`  out  $clog2(DEPTH)+1  entries held.
- `err`  out  1  sticky protocol error.

## Operation
- Storage is a circular FIFO of `DEPTH` x 65 bits (coordinate plus last flag), with read pointer, write pointer and count.
- The FIFO is show-ahead: `coord` is driven combinationally from the entry at the read pointer.
- The state machine has three states:
  - FILL: accepting writes.
  - DRAIN: last flag has been accepted; no further writes.
  - DONE: last entry has been popped.
- Transitions:
  - FILL→DRAIN on an accepted write with `wr_last`=1.
  - DRAIN→DONE on a pop of the entry whose flag is set.
  - FILL→DONE never occurs directly. A last entry accepted and popped in the same cycle is impossible, because there is no bypass.
  - Any state→FILL on `restart`.
- `wr_ready` = (state==FILL) && (count<DEPTH). A write is accepted when `wr_valid`&&`wr_ready`.
- Pop condition: `fetch_next`&&(count>0)&&(state!=DONE).
- Push and pop in the same cycle are both performed and count is unchanged. This cannot happen when full, because `wr_ready`=0.
- Output rules:
  - count>0: `coord`=head, `coord_valid`=1.
  - DONE: `coord`=`END`, `coord_valid`=1, `done`=1.
  - FILL with count==0: `coord`=`END`, `coord_valid`=0.
- `err` is set and held until reset or `restart` on either of:
  - `fetch_next` while `coord_valid`=0 (no pop occurs);
  - an accepted write with `wr_coord`==`END` (the entry is stored anyway).
- `fetch_next` in DONE is legal and ignored.
- `restart` has priority over every push and pop in its cycle. Next cycle the block is in FILL, pointers and count are 0, `done`=0 and `err`=0.
- Pointers wrap modulo `DEPTH`. Count saturates at neither bound because the guards prevent overflow and underflow.

## Timing
- Reset asserted (asynchronous): state=FILL, pointers=0, count=0.
  - Outputs: `coord`=`END`, `coord_valid`=0, `done`=0, `err`=0, `occupancy`=0, `wr_ready`=1.
  - Writes presented while `reset`=0 are dropped.
- Write latency: a write accepted at edge N appears on `coord` after edge N when the FIFO was empty; there is no same-cycle bypass.
- Pop latency: `fetch_next` sampled at edge N. The next head, or `END` with `done`=1, is visible after edge N. `occupancy` updates at the same edge.
- Reset mid-fiber discards all contents. `restart` does the same synchronously.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **Fill and drain:** write 3, 7, 12 (`wr_last` on 12), then pulse `fetch_next` 3 times.
  - Required: `coord` shows 3→7→12→`END`; `done` rises after the third pop; `wr_ready`=0 after 12 is accepted.
- **Full:** write 8 entries with no pops.
  - Required: `occupancy`=8 and `wr_ready`=0.
  - Then one pop with a concurrent `wr_valid`: the write is refused that cycle and accepted the next, `occupancy` returns to 8.
- **Steady state:** with `occupancy`=2, push and pop simultaneously for 20 cycles, with wrap-around.
  - Required: `occupancy` stays 2 and the coordinate order is preserved.
- **Errors:**
  - Pulse `fetch_next` on an empty FIFO in FILL: `err`=1, `occupancy` stays 0.
  - Write `END` in a separate run: `err`=1.
- **Restart:** `restart` with 4 entries held and `err`=1.
  - Required: next cycle `occupancy`=0, `done`=0, `err`=0, `coord_valid`=0.
  - A new fiber 5 (last) then yields `coord`=5.
- **Async reset:** assert `reset` low mid-DRAIN between clock edges.
  - Required: outputs take their reset values immediately, without waiting for a clock edge.
